bft_host_injector: RTL and testbench



---
 rtl/bft_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/bft_host_injector.sv | 115 +++++++++++
 tb/tb_bft_host_injector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT definitions: packet field layout, host word payload and packet packing.
package bft_pkg;

  localparam int unsigned PACKET_BITS    = 49;
  localparam int unsigned PAYLOAD_BITS   = 32;
  localparam int unsigned NUM_LEAF_BITS  = 3;
  localparam int unsigned NUM_PORT_BITS  = 4;
  localparam int unsigned FIFO_ADDR_BITS = 4;
  localparam int unsigned CNT_BITS       = 32;

  localparam int unsigned VALID_POS = PACKET_BITS - 1;
  localparam int unsigned LEAF_LSB  = VALID_POS - NUM_LEAF_BITS;
  localparam int unsigned PORT_LSB  = LEAF_LSB - NUM_PORT_BITS;
  localparam int unsigned PAD_BITS  = PORT_LSB - PAYLOAD_BITS;

  localparam logic [NUM_PORT_BITS-1:0] PORT_CFG0 = NUM_PORT_BITS'(0);
  localparam logic [NUM_PORT_BITS-1:0] PORT_CFG1 = NUM_PORT_BITS'(1);

  typedef struct packed {
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [PAYLOAD_BITS-1:0]  payload;
  } host_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

  // Valid bit on top, zero padding between the port field and the payload.
  function automatic logic [PACKET_BITS-1:0] pack_packet(input host_word_t w);
    return {1'b1, w.leaf, w.port, {PAD_BITS{1'b0}}, w.payload};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; read data is the head entry, full/empty are registered flags.
module sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata_c,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = ADDR_BITS + 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_next;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_push;
  logic                 w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Flags track the post-edge count so they are ready without a decode path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == CW'(0));
    end
  end

  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/bft_host_injector.sv
// Host-side BFT transmitter: queues tagged words, packs them and drives the root port,
// holding the current packet while the switch signals resend.
module bft_host_injector
  import bft_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_cfg,
  input  logic [NUM_LEAF_BITS-1:0]  s_leaf,
  input  logic [NUM_PORT_BITS-1:0]  s_port,
  input  logic [PAYLOAD_BITS-1:0]   s_payload,
  output logic [PACKET_BITS-1:0]    dout_host2bft,
  input  logic                      resend,
  output logic                      idle,
  output logic [CNT_BITS-1:0]       pkt_count,
  output logic                      port_err
);

  localparam int unsigned CW = FIFO_ADDR_BITS + 1;

  out_state_t             r_state;
  out_state_t             w_state_next;
  logic [PACKET_BITS-1:0] r_dout;
  logic [CNT_BITS-1:0]    r_pkt_count;
  logic                   r_port_err;
  logic                   r_idle;

  host_word_t             w_wdata;
  host_word_t             w_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;
  logic [CW-1:0]          w_fifo_count_next;
  logic                   w_drop;
  logic                   w_accept_in;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_out_accept;

  // Non-config words may not address the reserved configuration ports.
  assign w_drop      = !s_cfg && ((s_port == PORT_CFG0) || (s_port == PORT_CFG1));
  assign w_accept_in = s_valid && !w_fifo_full;
  assign w_push      = w_accept_in && !w_drop;
  assign w_wdata     = '{leaf: s_leaf, port: s_port, payload: s_payload};

  sync_fifo #(
    .WIDTH     ($bits(host_word_t)),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_wdata),
    .o_rdata_c (w_rdata),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_out_accept = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!resend) begin
          w_out_accept = 1'b1;
          if (!w_fifo_empty) w_pop = 1'b1;
          else               w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Occupancy after this edge, so idle can be registered alongside the state.
  always_comb begin
    w_fifo_count_next = w_fifo_count;
    if (w_push && !w_pop)      w_fifo_count_next = w_fifo_count + CW'(1);
    else if (!w_push && w_pop) w_fifo_count_next = w_fifo_count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_dout      <= '0;
      r_pkt_count <= '0;
      r_port_err  <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_pop)             r_dout <= pack_packet(w_rdata);
      else if (w_out_accept) r_dout <= '0;
      if (w_out_accept)      r_pkt_count <= r_pkt_count + CNT_BITS'(1);
      if (w_accept_in && w_drop) r_port_err <= 1'b1;
      r_idle <= (w_fifo_count_next == CW'(0)) && (w_state_next == ST_EMPTY);
    end
  end

  assign s_ready       = !w_fifo_full;
  assign dout_host2bft = r_dout;
  assign idle          = r_idle;
  assign pkt_count     = r_pkt_count;
  assign port_err      = r_port_err;

endmodule

// File: tb/tb_bft_host_injector.sv
// Directed bench for bft_host_injector: latency, resend hold, full FIFO, port errors,
// async reset and a randomised resend/push ordering check.
module tb_bft_host_injector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_cfg = 1'b0;
  logic [2:0]  s_leaf = '0;
  logic [3:0]  s_port = '0;
  logic [31:0] s_payload = '0;
  logic        resend = 1'b0;
  logic        s_ready;
  logic        idle;
  logic        port_err;
  logic [48:0] dout;
  logic [31:0] pkt_count;

  int n_cmp = 0;
  int n_fail = 0;
  int n_acc = 0;
  logic [48:0] q [$];
  logic [48:0] exp_pkt;

  bft_host_injector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_cfg         (s_cfg),
    .s_leaf        (s_leaf),
    .s_port        (s_port),
    .s_payload     (s_payload),
    .dout_host2bft (dout),
    .resend        (resend),
    .idle          (idle),
    .pkt_count     (pkt_count),
    .port_err      (port_err)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] pkt(input logic [2:0] l, input logic [3:0] p, input logic [31:0] d);
    return {1'b1, l, p, 9'd0, d};
  endfunction

  function automatic logic [2:0] wl(input int i);
    return 3'(i % 8);
  endfunction
  function automatic logic [3:0] wp(input int i);
    return 4'(2 + (i % 14));
  endfunction
  function automatic logic [31:0] wd(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [2:0] l, input logic [3:0] p, input logic [31:0] d);
    s_valid = 1'b1; s_cfg = c; s_leaf = l; s_port = p; s_payload = d;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_ready", 64'(s_ready), 64'h1);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_cnt", 64'(pkt_count), 64'h0);
    chk("rst_err", 64'(port_err), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single word, two-cycle latency
    drive(1'b0, 3'd3, 4'd2, 32'hDEADBEEF);
    tick();
    s_valid = 1'b0;
    chk("t1_busy", 64'(idle), 64'h0);
    chk("t1_notyet", 64'(dout), 64'h0);
    tick();
    chk("t1_pkt", 64'(dout), 64'(pkt(3'd3, 4'd2, 32'hDEADBEEF)));
    chk("t1_cnt0", 64'(pkt_count), 64'h0);
    tick();
    chk("t1_cnt", 64'(pkt_count), 64'h1);
    chk("t1_idle", 64'(idle), 64'h1);
    chk("t1_drain", 64'(dout), 64'h0);

    // 2: resend held for 5 edges keeps the packet for 6 cycles
    drive(1'b0, 3'd5, 4'd7, 32'hCAFEF00D);
    tick();
    s_valid = 1'b0;
    resend = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold", 64'(dout), 64'(pkt(3'd5, 4'd7, 32'hCAFEF00D)));
      chk("t2_cnt", 64'(pkt_count), 64'h1);
      tick();
    end
    chk("t2_hold6", 64'(dout), 64'(pkt(3'd5, 4'd7, 32'hCAFEF00D)));
    resend = 1'b0;
    tick();
    chk("t2_cnt_rel", 64'(pkt_count), 64'h2);
    chk("t2_drain", 64'(dout), 64'h0);

    // 3: fill FIFO behind a held packet, then drain back-to-back
    resend = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, wl(i), wp(i), wd(i));
      if (i == 16) chk("t3_ready_pre", 64'(s_ready), 64'h1);
      tick();
    end
    s_valid = 1'b0;
    chk("t3_full", 64'(s_ready), 64'h0);
    chk("t3_head", 64'(dout), 64'(pkt(wl(0), wp(0), wd(0))));
    resend = 1'b0;
    for (int i = 1; i < 17; i++) begin
      tick();
      chk("t3_order", 64'(dout), 64'(pkt(wl(i), wp(i), wd(i))));
      if (i == 1) chk("t3_ready_back", 64'(s_ready), 64'h1);
    end
    tick();
    chk("t3_drain", 64'(dout), 64'h0);
    chk("t3_cnt", 64'(pkt_count), 64'd19);
    chk("t3_idle", 64'(idle), 64'h1);

    // 4: reserved port without cfg is dropped; with cfg it goes out
    drive(1'b0, 3'd1, 4'd1, 32'hAAAA5555);
    chk("t4_err_pre", 64'(port_err), 64'h0);
    tick();
    s_valid = 1'b0;
    chk("t4_err", 64'(port_err), 64'h1);
    chk("t4_idle", 64'(idle), 64'h1);
    tick();
    chk("t4_nopkt", 64'(dout), 64'h0);
    drive(1'b1, 3'd6, 4'd0, 32'h12345678);
    tick();
    s_valid = 1'b0;
    tick();
    chk("t4_cfgpkt", 64'(dout), 64'(pkt(3'd6, 4'd0, 32'h12345678)));
    tick();
    chk("t4_cnt", 64'(pkt_count), 64'd20);
    chk("t4_sticky", 64'(port_err), 64'h1);

    // 5: async reset with a held packet and 4 queued
    resend = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, wl(i + 20), wp(i + 20), wd(i + 20));
      tick();
    end
    s_valid = 1'b0;
    chk("t5_held", 64'(dout), 64'(pkt(wl(20), wp(20), wd(20))));
    chk("t5_busy", 64'(idle), 64'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_dout", 64'(dout), 64'h0);
    chk("t5_idle", 64'(idle), 64'h1);
    chk("t5_cnt", 64'(pkt_count), 64'h0);
    chk("t5_err", 64'(port_err), 64'h0);
    chk("t5_ready", 64'(s_ready), 64'h1);
    @(negedge clk);
    reset_n = 1'b1;
    resend = 1'b0;
    tick();
    tick();
    chk("t5_discard", 64'(dout), 64'h0);
    chk("t5_idle2", 64'(idle), 64'h1);

    // 6: random resend with concurrent pushes, scoreboard ordering
    for (int cyc = 0; cyc < 300; cyc++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_cfg = 1'($urandom_range(0, 1));
      s_leaf = 3'($urandom_range(0, 7));
      s_port = 4'($urandom_range(2, 15));
      s_payload = $urandom;
      resend = ($urandom_range(0, 2) == 0);
      if (dout[48] && !resend) begin
        if (q.size() == 0) chk("t6_spurious", 64'(dout), 64'h0);
        else begin
          exp_pkt = q.pop_front();
          chk("t6_seq", 64'(dout), 64'(exp_pkt));
          n_acc++;
        end
      end
      if (s_valid && s_ready) q.push_back(pkt(s_leaf, s_port, s_payload));
      tick();
    end
    s_valid = 1'b0;
    resend = 1'b0;
    for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
      if (dout[48]) begin
        exp_pkt = q.pop_front();
        chk("t6_drain_seq", 64'(dout), 64'(exp_pkt));
        n_acc++;
      end
      tick();
    end
    chk("t6_left", 64'(q.size()), 64'h0);
    chk("t6_cnt", 64'(pkt_count), 64'(n_acc));
    chk("t6_empty", 64'(dout), 64'h0);
    chk("t6_idle", 64'(idle), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
